// File: rtl/anim_sequencer.sv
// anim_sequencer
//   Frame-animation controller for a 5x7 LED matrix. Captures up to DEPTH
//   35-bit frames from the picture editor into an internal frame store and
//   plays them back in a loop, showing each frame for DWELL cycles. It also
//   owns the row/column scan of the matrix.
//
// Ports
//   CLOCK_50   in   system clock
//   rst        in   asynchronous, active-high reset
//   en         in   block enable; when low the matrix is blanked and commands are ignored
//   frame_in   in   editor frame, bit r*7+c = row r, column c, 1 = lit
//   store      in   pulse: append frame_in to the store
//   clear      in   pulse: empty the store (contents are kept, count drops to 0)
//   play       in   pulse: toggle between play and stop
//   row        out  one-hot row select, active-high (registered)
//   column     out  column data for the selected row, active-high (registered)
//   frame_idx  out  index of the frame currently displayed
//   count      out  number of frames stored
//   playing    out  high while in the PLAY state
module anim_sequencer #(
  parameter int DEPTH    = 8,           // power of two, 2..16
  parameter int DWELL    = 25_000_000,  // cycles each frame is shown while playing
  parameter int SCAN_DIV = 50_000,      // cycles each row stays selected
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int CNT_W   = IDX_W + 1
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             en,
  input  logic [34:0]      frame_in,
  input  logic             store,
  input  logic             clear,
  input  logic             play,
  output logic [4:0]       row,
  output logic [6:0]       column,
  output logic [IDX_W-1:0] frame_idx,
  output logic [CNT_W-1:0] count,
  output logic             playing
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SC_W-1:0]  SCAN_LAST  = SC_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_STOP,
    S_PLAY
  } state_e;

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [IDX_W-1:0] frame_idx_q, frame_idx_d;
  logic [DW_W-1:0]  dwell_q,     dwell_d;
  logic [SC_W-1:0]  scan_q,      scan_d;
  logic [2:0]       row_sel_q,   row_sel_d;
  logic [4:0]       row_q,       row_d;
  logic [6:0]       column_q,    column_d;
  logic             playing_q,   playing_d;

  logic [34:0]      frame_mem_q [DEPTH];
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [34:0]      disp;

  // Live editor frame while nothing is stored, otherwise the selected stored frame.
  assign disp = (state_q == S_EMPTY) ? frame_in : frame_mem_q[frame_idx_q];

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred;
    // blocking assignments are correct in combinational logic.
    state_d     = state_q;
    count_d     = count_q;
    frame_idx_d = frame_idx_q;
    dwell_d     = '0;
    scan_d      = '0;
    row_sel_d   = '0;
    row_d       = '0;
    column_d    = '0;
    wr_en       = 1'b0;
    wr_addr     = count_q[IDX_W-1:0];

    if (en) begin
      // Row scan: each row held SCAN_DIV cycles, rows 0..4 in turn.
      if (scan_q == SCAN_LAST) begin
        scan_d    = '0;
        row_sel_d = (row_sel_q == 3'd4) ? 3'd0 : row_sel_q + 3'd1;
      end else begin
        scan_d    = scan_q + SC_W'(1);
        row_sel_d = row_sel_q;
      end
      row_d    = 5'b00001 << row_sel_q;
      column_d = disp[row_sel_q*7 +: 7];

      // Dwell timer only runs while playing; it wraps the frame index at count-1.
      if (state_q == S_PLAY) begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d     = '0;
          frame_idx_d = ({1'b0, frame_idx_q} == count_q - CNT_W'(1)) ? '0
                                                                     : frame_idx_q + IDX_W'(1);
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end

      // Commands: clear > store > play. An asserted store masks play even
      // when the store itself is refused (PLAY or full).
      if (clear) begin
        count_d     = '0;
        frame_idx_d = '0;
        state_d     = S_EMPTY;
        dwell_d     = '0;
      end else if (store) begin
        if (state_q != S_PLAY && count_q != DEPTH_C) begin
          wr_en       = 1'b1;
          count_d     = count_q + CNT_W'(1);
          frame_idx_d = count_q[IDX_W-1:0];
          state_d     = S_STOP;
        end
      end else if (play) begin
        case (state_q)
          S_STOP: begin
            state_d = S_PLAY;
            dwell_d = '0;
          end
          S_PLAY: begin
            state_d     = S_STOP;
            frame_idx_d = frame_idx_q;
            dwell_d     = '0;
          end
          default: ;
        endcase
      end
    end

    playing_d = (state_d == S_PLAY);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      count_q     <= '0;
      frame_idx_q <= '0;
      dwell_q     <= '0;
      scan_q      <= '0;
      row_sel_q   <= '0;
      row_q       <= '0;
      column_q    <= '0;
      playing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      frame_idx_q <= frame_idx_d;
      dwell_q     <= dwell_d;
      scan_q      <= scan_d;
      row_sel_q   <= row_sel_d;
      row_q       <= row_d;
      column_q    <= column_d;
      playing_q   <= playing_d;
    end
  end

  // NOTE: the frame store is reset because reset must leave every entry at 0;
  // with DEPTH <= 16 it is built from flops, so the reset costs nothing special.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) frame_mem_q[i] <= '0;
    end else if (wr_en) begin
      frame_mem_q[wr_addr] <= frame_in;
    end
  end

  assign row       = row_q;
  assign column    = column_q;
  assign frame_idx = frame_idx_q;
  assign count     = count_q;
  assign playing   = playing_q;

endmodule
